// File: rtl/hilo_mdu_pkg.sv
// hilo_mdu_pkg: shared definitions for the E-stage multiply/divide unit.
//   - hilo_op_e : HILOOp encodings carried in the E-stage pipeline register
//   - MULT_CYCLES_DEF / DIV_CYCLES_DEF : default latencies, shared with the
//     hazard unit so stall windows match the unit's occupancy.
package hilo_mdu_pkg;

  typedef enum logic [3:0] {
    HILO_NONE  = 4'd0,
    HILO_MULT  = 4'd1,
    HILO_MULTU = 4'd2,
    HILO_DIV   = 4'd3,
    HILO_DIVU  = 4'd4,
    HILO_MTHI  = 4'd5,
    HILO_MTLO  = 4'd6,
    HILO_MFHI  = 4'd7,
    HILO_MFLO  = 4'd8
  } hilo_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/hilo_mdu_arith.sv
// hilo_mdu_arith: combinational 64-bit result for mult/multu/div/divu.
//   op     in  4   HILOOp code
//   a, b   in  32  operands (rs, rt)
//   result out 64  {HI, LO}
//   wr_en  out 1   result should be committed to HI/LO (low for divide by 0
//                  and for non-arithmetic ops)
module hilo_mdu_arith
  import hilo_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        wr_en
);

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] sa, sb, sq, sr;
  logic        [31:0] ub, uq, ur;
  logic               b_zero, s_ovf;

  always_comb begin
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};

    b_zero = (b == '0);
    // Divisor forced to 1 when zero so the divider never sees x/0; the
    // result is discarded through wr_en anyway.
    ub = b_zero ? 32'd1 : b;
    sa = signed'(a);
    sb = signed'(ub);
    // Most-negative / -1 overflows a 32-bit quotient; pin the defined answer.
    s_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (s_ovf) begin
      sq = signed'(32'h8000_0000);
      sr = '0;
    end else begin
      sq = sa / sb;
      sr = sa % sb;
    end
    uq = a / ub;
    ur = a % ub;

    result = '0;
    wr_en  = 1'b0;
    case (op)
      HILO_MULT:  begin result = prod_s;                      wr_en = 1'b1;    end
      HILO_MULTU: begin result = prod_u;                      wr_en = 1'b1;    end
      HILO_DIV:   begin result = {unsigned'(sr), unsigned'(sq)}; wr_en = ~b_zero; end
      HILO_DIVU:  begin result = {ur, uq};                    wr_en = ~b_zero; end
      default:    begin result = '0;                          wr_en = 1'b0;    end
    endcase
  end

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: E-stage multiply/divide unit with HI/LO registers.
//   clk         in  1   pipeline clock
//   clr         in  1   synchronous active-low reset
//   A_E_I       in  32  forwarded rs
//   B_E_I       in  32  forwarded rt
//   HILOOp_E_I  in  4   operation code (hilo_op_e; 9-15 act as NONE)
//   Start_E_O   out 1   mult/div accepted this cycle (combinational)
//   Busy_E_O    out 1   operation in flight (registered)
//   HILO_E_O    out 32  HI for mfhi, LO for mflo, else 0 (combinational)
// The result is computed at acceptance and parked in pending registers;
// HI/LO keep their old values until the final busy cycle commits them.
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] A_E_I,
  input  logic [31:0] B_E_I,
  input  logic [3:0]  HILOOp_E_I,
  output logic        Start_E_O,
  output logic        Busy_E_O,
  output logic [31:0] HILO_E_O
);

  localparam int MAXN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXN + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e        state, state_nx;
  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo;
  logic [63:0]   pend;
  logic          pend_we;

  logic [63:0]   arith_res;
  logic          arith_we;
  logic          is_arith, is_mult, done;

  hilo_mdu_arith u_arith (
    .op     (HILOOp_E_I),
    .a      (A_E_I),
    .b      (B_E_I),
    .result (arith_res),
    .wr_en  (arith_we)
  );

  always_comb begin
    is_mult   = (HILOOp_E_I == HILO_MULT) || (HILOOp_E_I == HILO_MULTU);
    is_arith  = is_mult || (HILOOp_E_I == HILO_DIV) || (HILOOp_E_I == HILO_DIVU);
    Busy_E_O  = (state == ST_BUSY);
    Start_E_O = is_arith && !Busy_E_O;
    done      = Busy_E_O && (cnt == '0);

    HILO_E_O = '0;
    if (HILOOp_E_I == HILO_MFHI)      HILO_E_O = hi;
    else if (HILOOp_E_I == HILO_MFLO) HILO_E_O = lo;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (Start_E_O) state_nx = ST_BUSY;
      ST_BUSY: if (done)      state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
      pend    <= '0;
      pend_we <= 1'b0;
    end else if (Busy_E_O) begin
      if (done) begin
        if (pend_we) begin
          hi <= pend[63:32];
          lo <= pend[31:0];
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (Start_E_O) begin
      pend    <= arith_res;
      pend_we <= arith_we;
      cnt     <= is_mult ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
    end else if (HILOOp_E_I == HILO_MTHI) begin
      hi <= A_E_I;
    end else if (HILOOp_E_I == HILO_MTLO) begin
      lo <= A_E_I;
    end
  end

endmodule
